// File: rtl/arb_pkg.sv
// Shared types for the four-way round-robin arbiter: FSM encoding, client count, index type.
package arb_pkg;

    localparam int NUM_REQ = 4;

    typedef logic [1:0] idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    // Next client in rotation; the 2-bit width provides the 3 -> 0 wrap.
    function automatic idx_t idx_next(input idx_t i);
        return i + 2'd1;
    endfunction

endpackage

// File: rtl/decoder_2x4.sv
// Purpose: 2-to-4 one-hot decoder for the winner index.
// Latency: purely combinational, zero cycles.
// Backpressure: none, a pure function of its input.
module decoder_2x4 (
    input  logic [1:0] sel,
    output logic [3:0] onehot
);

    always_comb begin
        onehot      = 4'b0000;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// Purpose: four-client round-robin arbiter with a bounded tenure and a one-cycle gap between tenures.
// Latency: a request sampled at edge N is granted in cycle N+1; a released or expired grant drops at the sampling edge.
// Backpressure: en low blocks new grants only; an active tenure runs until release or the hold limit.
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic [7:0] hold_cnt
);

    // At least one bit, so that MAX_HOLD = 1 still has a legal counter.
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    arb_state_t    state;
    idx_t          ptr;
    logic [HW-1:0] hold_q;
    logic [3:0]    dec_onehot;
    logic          pick_vld;
    idx_t          pick_idx;

    // Scan from the highest offset down, so the client nearest ptr is the last one written and wins.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input idx_t p);
        logic [2:0] res;
        idx_t       c;
        res = 3'b000;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            c = p + idx_t'(k);
            if (r[c]) begin
                res = {1'b1, c};
            end
        end
        return res;
    endfunction

    always_comb begin
        {pick_vld, pick_idx} = rr_pick(req, ptr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            hold_q    <= '0;
        end else begin
            unique case (state)
                IDLE, GAP: begin
                    if (en && pick_vld) begin
                        state     <= GRANT;
                        gnt_idx   <= pick_idx;
                        gnt_valid <= 1'b1;
                        hold_q    <= '0;
                    end else begin
                        state     <= IDLE;
                        gnt_valid <= 1'b0;
                    end
                end
                GRANT: begin
                    // A release and a hold expiry at the same edge are one exit, so ptr moves once.
                    if (!req[gnt_idx] || (hold_q == HOLD_LAST)) begin
                        state     <= GAP;
                        ptr       <= idx_next(gnt_idx);
                        gnt_valid <= 1'b0;
                        hold_q    <= '0;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

    decoder_2x4 u_dec (
        .sel    (gnt_idx),
        .onehot (dec_onehot)
    );

    assign gnt      = dec_onehot & {NUM_REQ{gnt_valid}};
    assign hold_cnt = 8'(hold_q);

endmodule
